// File: rtl/serial_byte_loader_pkg.sv
// Shared types and helpers for the serial byte loader.
//   state_e    : frame FSM states (IDLE waits for start, SHIFT collects bits)
//   cnt_width(): bit-counter width for a given frame width
package serial_loader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_byte_loader_if.sv
// Bus between an upstream serial source and the serial byte loader.
//   start, bit_valid, bit_in : serial frame stream (source -> loader)
//   we, write_data           : register write port (loader -> parent)
//   busy, frame_err          : frame status (loader -> source)
interface serial_byte_loader_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             bit_valid;
  logic             bit_in;
  logic             we;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             frame_err;

  // Upstream side: drives the stream, observes results.
  modport master (
    output start,
    output bit_valid,
    output bit_in,
    input  we,
    input  write_data,
    input  busy,
    input  frame_err
  );

  // Loader side.
  modport slave (
    input  start,
    input  bit_valid,
    input  bit_in,
    output we,
    output write_data,
    output busy,
    output frame_err
  );

endinterface

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel front end for a WIDTH-bit write-enabled register.
// Collects a start-framed bit stream, then issues a one-cycle we with the
// assembled word. An abort (start during a frame) sets sticky frame_err.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of serial_byte_loader_if (stream in, write port out)
module serial_byte_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_byte_loader_if.slave  bus
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   shifted_c;
  logic               commit_c;
  logic               abort_c;

  logic               we_q, we_d;
  logic [WIDTH-1:0]   write_data_q, write_data_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      we_q         <= 1'b0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      we_q         <= we_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state: framing, bit counting and shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    commit_c = 1'b0;
    abort_c  = 1'b0;

    if (MSB_FIRST) begin
      shifted_c = {shreg_q[WIDTH-2:0], bus.bit_in};
    end else begin
      shifted_c = {bus.bit_in, shreg_q[WIDTH-1:1]};
    end

    unique case (state_q)
      IDLE: begin
        // bit_valid is ignored here, even alongside start.
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          // Abort: drop the partial word and restart the frame in place.
          abort_c = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (bus.bit_valid) begin
          shreg_d = shifted_c;
          if (cnt_q == LAST_CNT) begin
            commit_c = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values; the commit word includes the bit sampled this cycle.
  always_comb begin
    we_d         = commit_c;
    write_data_d = commit_c ? shreg_d : write_data_q;
    busy_d       = (state_d == SHIFT);
    frame_err_d  = frame_err_q;
    if (abort_c) begin
      frame_err_d = 1'b1;
    end else if (commit_c) begin
      frame_err_d = 1'b0;
    end
  end

  assign bus.we         = we_q;
  assign bus.write_data = write_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
- Serial-to-parallel front end for the 8-bit write-enabled register.
- Collects a framed serial bit stream, assembles WIDTH bits, then drives write_data and a single-cycle we pulse directly into the register's write port.
- Flags aborted frames so software or upstream logic can detect a lost byte.

Parameters:
- WIDTH, 8, number of bits per frame; equals the downstream register width; legal range ≥ 2.
- MSB_FIRST, 1, 1 = first received bit lands in write_data[WIDTH-1]; 0 = first bit lands in write_data[0].

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  one-cycle frame-start strobe.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit.
- we  output  1  one-cycle write strobe to the downstream register.
- write_data  output  WIDTH  assembled word; holds the last committed value.
- busy  output  1  frame in progress (state SHIFT).
- frame_err  output  1  sticky: last frame was aborted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, bit count=0, shift register=0.
  - write_data=0, we=0, busy=0, frame_err=0.
  - Reset mid-frame discards the partial frame; no we pulse is issued.
- States: IDLE, SHIFT (enum in package). busy = (state==SHIFT), registered.
- IDLE:
  - start=1 -> SHIFT, count=0, shift register cleared.
  - bit_valid is ignored in IDLE, including a bit_valid coincident with start.
  - The first data bit is sampled at the earliest one cycle after start.
- SHIFT, bit_valid=1 and start=0:
  - Sample bit_in.
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
  - count increments.
  - Cycles with bit_valid=0 hold all state; gaps of any length are allowed, with no timeout.
- Final bit (count==WIDTH-1 and bit_valid=1 in SHIFT):
  - At the same edge: write_data <= full assembled word (including this bit), we <= 1, frame_err <= 0, state -> IDLE.
  - we is high for exactly one cycle, then returns to 0.
  - Latency: we and write_data are valid in the cycle immediately after the edge that samples the WIDTH-th bit.
- start=1 while in SHIFT (abort):
  - Partial frame discarded; frame_err <= 1; count=0; shift register cleared; state stays SHIFT (new frame begins).
  - bit_valid in that cycle is ignored.
  - write_data unchanged; no we.
- start in the cycle where we=1:
  - State is already IDLE, so this is a normal start; no error.
  - Back-to-back frames are therefore possible with no dead cycle beyond the start cycle.
- frame_err:
  - Set only by an abort.
  - Cleared only by a successful commit or by reset.
  - A new start does not clear it.
- Counter width: $clog2(WIDTH) bits. Count never exceeds WIDTH-1; no wrap is needed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package serial_loader_pkg: state enum typedef (IDLE, SHIFT), and a localparam function for the counter width.
- No sub-module; shift register and FSM live in one always_ff.
- The downstream register is instantiated by the parent, which connects we and write_data to it.

Test Plan:
- MSB_FIRST=1: start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles.
  -> we=1 for one cycle, one cycle after the 8th bit; write_data=0xA5; busy falls with we; frame_err=0.
- Same 0xA5 stream with bit_valid=0 gaps of 3 cycles between bits.
  -> identical result; we asserted once; write_data stable at 0x00 until commit.
- Start, 4 bits, start again, then the full 0x3C stream.
  -> frame_err=1 after the abort; no we at abort; final write_data=0x3C; frame_err clears to 0 in the commit cycle.
- MSB_FIRST=0: bits 1,0,1,0,0,0,0,0 -> write_data=0x05.
- Commit 0xFF, then start, 5 bits, rst_n=0 for 1 cycle.
  -> write_data=0x00, we=0, busy=0, frame_err=0; a subsequent full frame of 0x81 commits normally.
- start asserted in the we cycle of 0xA5, followed by 0x5A bits.
  -> two we pulses, write_data 0xA5 then 0x5A; frame_err stays 0.
